dma_xfer_ctrl: RTL
==================

DMA_XFER_CTRL -- requirements
Module: dma_xfer_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address bus width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data word width.
REQ-003 Parameter LEN_W, default 8, SHALL set the transfer-length counter width.
REQ-004 Port clk, input, 1, SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port start, input, 1, SHALL be the gated DMA request (AND of enable conditions from the upstream gate stage).
REQ-007 Port src_addr, input, ADDR_W, SHALL be the first source address.
REQ-008 Port dst_addr, input, ADDR_W, SHALL be the first destination address.
REQ-009 Port len, input, LEN_W, SHALL be the word count.
REQ-010 Port bus_gnt, input, 1, SHALL be the bus grant from the CPU arbiter.
REQ-011 Port mem_rdy, input, 1, SHALL be the memory-ready beat acknowledge.
REQ-012 Port rd_data, input, DATA_W, SHALL be the memory read data, valid when mem_rdy is high in READ.
REQ-013 Port bus_req, output, 1, SHALL be the bus request to the arbiter.
REQ-014 Port rd_en / wr_en, outputs, 1 each, SHALL be the memory read and write strobes.
REQ-015 Port addr, output, ADDR_W, SHALL be the memory address.
REQ-016 Port wr_data, output, DATA_W, SHALL be the write data (the internal holding register).
REQ-017 Port busy / done, outputs, 1 each, SHALL be the transfer-active flag and the one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, REQ, READ, WRITE and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch src_addr, dst_addr and len into cur_src, cur_dst and remaining.
REQ-020 From that IDLE/start edge, the FSM SHALL go to DONE if len==0 and to REQ otherwise.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 REQ SHALL drive bus_req=1 and SHALL move to READ on the first cycle bus_gnt=1.
REQ-023 bus_req SHALL stay 1 in READ and WRITE.
REQ-024 READ SHALL drive rd_en=1 and addr=cur_src.
REQ-025 In READ with mem_rdy=1, the block SHALL capture rd_data into the holding register and move to WRITE.
REQ-026 WRITE SHALL drive wr_en=1, addr=cur_dst and wr_data=holding register.
REQ-027 In WRITE with mem_rdy=1, cur_src and cur_dst SHALL increment by 1 and remaining SHALL decrement by 1.
REQ-028 On that WRITE beat, the FSM SHALL go to DONE if remaining was 1 and to READ otherwise.
REQ-029 Address increments SHALL wrap modulo 2^ADDR_W with no error flag.
REQ-030 If bus_gnt=0 while mem_rdy=0 in READ or WRITE, the FSM SHALL return to REQ and retry the same beat; counters and the holding register SHALL be unchanged, and a re-read SHALL overwrite the holding register.
REQ-031 If bus_gnt falls in the same cycle as mem_rdy rises, the beat SHALL complete (mem_rdy wins).
REQ-032 DONE SHALL assert done=1 for exactly one cycle with bus_req=0, then go to IDLE.
REQ-033 busy SHALL be 1 in REQ, READ, WRITE and DONE, and 0 in IDLE.
REQ-034 rd_en and wr_en SHALL never be 1 in the same cycle.
REQ-035 All outputs SHALL be decoded from registered state only (Moore).
REQ-036 Per-word latency SHALL be at least 2 cycles (1 READ + 1 WRITE with mem_rdy=1).
REQ-037 With bus_gnt and mem_rdy held high, a transfer of N words SHALL take 1 REQ + 2N + 1 DONE cycles.

Reset
REQ-038 While rst_n=0, the FSM SHALL be in IDLE.
REQ-039 While rst_n=0, bus_req, rd_en, wr_en, busy and done SHALL be 0, and addr, wr_data, cur_src, cur_dst and remaining SHALL be 0.
REQ-040 Reset asserted mid-transfer SHALL abort immediately without a done pulse.
REQ-041 After reset, the block SHALL need a fresh start to begin a new transfer.

Structure
REQ-042 State encodings and the default widths SHALL live in shared package dma_pkg.
REQ-043 The address/length counter set SHALL be a sub-module named dma_addr_cnt; the FSM SHALL be the only other logic.

Verification
REQ-044 Single word: src=0x10, dst=0x80, len=1, gnt=1, rdy=1, rd_data=0xA5 -> one write of 0xA5 at 0x80; done exactly 4 cycles after start.
REQ-045 Burst with wrap: src=0xFE, dst=0x20, len=3 -> reads at 0xFE, 0xFF, 0x00 and writes at 0x20, 0x21, 0x22, in order.
REQ-046 Zero length: len=0 -> done one cycle after start; bus_req, rd_en and wr_en never assert.
REQ-047 Grant loss: bus_gnt drops in the READ of word 2 of len=4, returns after 3 cycles -> word 2 is re-read from the same address; exactly 4 writes occur.
REQ-048 Reset mid-transfer: rst_n low during WRITE of len=5 -> all outputs 0 the same cycle, no done; the next start runs a full transfer.
REQ-049 Start while busy: start pulsed during READ with different addresses -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/dma_pkg.sv
// DMA transfer controller shared package.
// Default widths and the controller state encoding.
package dma_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/dma_addr_cnt.sv
// Source/destination address and remaining-word counters.
// Ports: load (latch src_in/dst_in/len_in), step (advance one word),
// cur_src/cur_dst/remaining (state), last (remaining==1).
module dma_addr_cnt
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic [LEN_W-1:0]  remaining,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_src   <= src_in;
      cur_dst   <= dst_in;
      remaining <= len_in;
    end else if (step) begin
      // addresses wrap naturally at 2^ADDR_W
      cur_src   <= cur_src + ADDR_W'(1);
      cur_dst   <= cur_dst + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA controller: bus request, read beat, write beat.
// Ports: start/src_addr/dst_addr/len in, bus_gnt/mem_rdy/rd_data from
// bus, bus_req/rd_en/wr_en/addr/wr_data to bus, busy/done status.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              bus_gnt,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] rd_data,
  output logic              bus_req,
  output logic              rd_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [DATA_W-1:0]   hold;
  logic [ADDR_W-1:0]   cur_src;
  logic [ADDR_W-1:0]   cur_dst;
  logic [LEN_W-1:0]    remaining;
  logic                last;
  logic                load;
  logic                step;

  assign load = (state == S_IDLE) && start;
  assign step = (state == S_WRITE) && mem_rdy;

  dma_addr_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .src_in    (src_addr),
    .dst_in    (dst_addr),
    .len_in    (len),
    .cur_src   (cur_src),
    .cur_dst   (cur_dst),
    .remaining (remaining),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hold  <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (start)
            state <= (len == '0) ? S_DONE : S_REQ;
        S_REQ:
          if (bus_gnt)
            state <= S_READ;
        S_READ:
          // a completing beat beats a lost grant
          if (mem_rdy) begin
            hold  <= rd_data;
            state <= S_WRITE;
          end else if (!bus_gnt) begin
            state <= S_REQ;
          end
        S_WRITE:
          if (mem_rdy)
            state <= last ? S_DONE : S_READ;
          else if (!bus_gnt)
            state <= S_REQ;
        S_DONE:
          state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign bus_req = (state == S_REQ) || (state == S_READ) ||
                   (state == S_WRITE);
  assign rd_en   = (state == S_READ);
  assign wr_en   = (state == S_WRITE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign wr_data = hold;

  always_comb begin
    addr = '0;
    unique case (state)
      S_READ:  addr = cur_src;
      S_WRITE: addr = cur_dst;
      default: addr = '0;
    endcase
  end

endmodule
